// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} mem_size_e;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_e;

  localparam int unsigned WS_CNT_W = 4;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: store data/byte-enables and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] wdata,
  input  mem_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    case (size)
      SZ_B: begin
        be         = 4'(4'b0001 << offset);
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      SZ_W: begin
        be         = '1;
        wdata_lane = wdata;
      end
      default: begin
        be         = '0;
        wdata_lane = '0;
      end
    endcase
  end

  always_comb begin
    rbyte = 8'(rword >> {offset, 3'b000});
    rhalf = offset[1] ? rword[31:16] : rword[15:0];
    rdata = '0;
    case (size)
      SZ_B:    rdata = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      SZ_H:    rdata = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      SZ_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store front end with wait states over on-chip RAM.
// Optional DMEM_MMIO_EN adds a single word-wide MMIO register just past the RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0]           mmio_o
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  dmem_state_e         state, state_next;
  logic [WS_CNT_W-1:0] cnt, cnt_next;
  logic                commit;

  logic [31:0] cap_addr, cap_wdata;
  mem_size_e   cap_size;
  logic        cap_we, cap_uns;

  logic [31:0] src_addr, src_wdata;
  mem_size_e   src_size;
  logic        src_we, src_uns;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          misalign, in_ram, err;
  logic [3:0]    be;
  logic [31:0]   wdata_lane, rword, rdata_ext;

  logic [31:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = WS_CNT_W'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        if (cnt == WS_CNT_W'(1)) begin
          state_next = RESP;
          cnt_next   = '0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid_i) begin
      cap_addr  <= req_addr_i;
      cap_wdata <= req_wdata_i;
      cap_size  <= mem_size_e'(req_size_i);
      cap_we    <= req_we_i;
      cap_uns   <= req_unsigned_i;
    end
  end

  // With zero wait states the commit edge is the accept edge, so the access
  // must come straight from the request inputs rather than the capture regs.
  always_comb begin
    if (state == IDLE) begin
      src_addr  = req_addr_i;
      src_wdata = req_wdata_i;
      src_size  = mem_size_e'(req_size_i);
      src_we    = req_we_i;
      src_uns   = req_unsigned_i;
    end else begin
      src_addr  = cap_addr;
      src_wdata = cap_wdata;
      src_size  = cap_size;
      src_we    = cap_we;
      src_uns   = cap_uns;
    end
  end

  assign off      = src_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign in_ram   = (off < RAM_BYTES);
  assign misalign = (src_size == SZ_X)
                  || (src_size == SZ_H && src_addr[0])
                  || (src_size == SZ_W && src_addr[1:0] != 2'b00);

`ifdef DMEM_MMIO_EN
  logic        mmio_hit;
  logic [31:0] mmio_q;

  assign mmio_hit = (off == RAM_BYTES) && (src_size == SZ_W);
  assign err      = misalign || (!in_ram && !mmio_hit);
  assign rword    = in_ram ? ram[idx] : mmio_q;
  assign mmio_o   = mmio_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mmio_q <= '0;
    end else if (commit && src_we && !err && mmio_hit) begin
      mmio_q <= src_wdata;
    end
  end
`else
  assign err   = misalign || !in_ram;
  assign rword = ram[idx];
`endif

  dmem_lane_align u_align (
    .wdata       (src_wdata),
    .size        (src_size),
    .offset      (src_addr[1:0]),
    .is_unsigned (src_uns),
    .rword       (rword),
    .be          (be),
    .wdata_lane  (wdata_lane),
    .rdata       (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst && commit && src_we && !err && in_ram) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (commit) begin
      rsp_rdata_o <= (err || src_we) ? '0 : rdata_ext;
      rsp_err_o   <= err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          WS   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_valid = 1'b0, z_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [1:0]  z_size = '0;
  logic        z_ready, z_rsp_valid, z_err;
  logic [31:0] z_rdata;

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio, z_mmio;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_b [0:4095];
  logic [31:0] mmio_m = '0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
`ifdef DMEM_MMIO_EN
    , .mmio_o(mmio)
`endif
  );

  dmem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(z_valid), .req_ready_o(z_ready), .req_we_i(z_we),
    .req_addr_i(z_addr), .req_wdata_i(z_wdata), .req_size_i(z_size),
    .req_unsigned_i(1'b0), .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
    .rsp_rdata_o(z_rdata), .rsp_err_o(z_err)
`ifdef DMEM_MMIO_EN
    , .mmio_o(z_mmio)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic err, output logic [31:0] rd);
    logic [31:0] off, val, tmp;
    logic        mmio_ok;
    int          nb;
    off     = addr - BASE;
    mmio_ok = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_ok = (off == 32'd4096) && (size == 2'd2);
`endif
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)
          || (off >= 32'd4096 && !mmio_ok);
    rd  = '0;
    if (err) return;
    if (mmio_ok) begin
      if (we) mmio_m = wdata;
      else    rd = mmio_m;
      return;
    end
    nb = 1 << size;
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        tmp = wdata >> (8 * i);
        mem_b[off[11:0] + 12'(i)] = tmp[7:0];
      end
    end else begin
      val = '0;
      for (int i = 0; i < nb; i++) val |= 32'(mem_b[off[11:0] + 12'(i)]) << (8 * i);
      if (!uns && nb < 4 && val[8*nb-1]) val |= ~((32'd1 << (8 * nb)) - 32'd1);
      rd = val;
    end
  endfunction

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          n;
    model(we, addr, wdata, size, uns, e_err, e_rd);
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_uns = uns;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(WS + 1));
    check("rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("rsp_rdata", rsp_rdata, e_rd);
    check("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, e_rd);
      check("hold_err", {31'h0, rsp_err}, {31'h0, e_err});
      check("hold_req_ready", {31'h0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_ready", {31'h0, req_ready}, 32'd1);
    check("post_hs_valid", {31'h0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
`ifdef DMEM_MMIO_EN
    check("rst_mmio", mmio, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 16; w++) xact(1'b1, BASE + 32'(4 * w), $urandom, 2'd2, 1'b0, 0);

    xact(1'b1, BASE + 32'd8, 32'hDEADBEEF, 2'd2, 1'b0, 0);
    xact(1'b0, BASE + 32'd8, 32'h0, 2'd2, 1'b0, 0);
    xact(1'b1, BASE + 32'd9, 32'h0000_0080, 2'd0, 1'b0, 0);
    xact(1'b0, BASE + 32'd9, 32'h0, 2'd0, 1'b0, 0);
    check("lb_sext_model", rsp_rdata, 32'hFFFFFF80);
    xact(1'b0, BASE + 32'd9, 32'h0, 2'd0, 1'b1, 0);
    xact(1'b0, BASE + 32'd8, 32'h0, 2'd2, 1'b0, 0);
    check("lw_after_sb", rsp_rdata, 32'hDEAD80EF);
    xact(1'b0, BASE + 32'd1, 32'h0, 2'd1, 1'b0, 0);
    xact(1'b1, BASE - 32'd4, 32'h5555_AAAA, 2'd2, 1'b0, 0);
    xact(1'b0, BASE + 32'd8, 32'h0, 2'd2, 1'b0, 5);

    // Reset during BUSY drops the store and its response.
    @(negedge clk);
    req_we = 1'b1; req_addr = BASE; req_wdata = 32'h1234; req_size = 2'd2; req_uns = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", {31'h0, rsp_valid}, 32'd0);
    end
    xact(1'b0, BASE, 32'h0, 2'd2, 1'b0, 0);

`ifdef DMEM_MMIO_EN
    xact(1'b1, BASE + 32'd4096, 32'h5, 2'd2, 1'b0, 0);
    check("mmio_val", mmio, 32'h5);
`else
    xact(1'b1, BASE + 32'd4096, 32'h5, 2'd2, 1'b0, 0);
`endif
    xact(1'b0, BASE + 32'd4096, 32'h0, 2'd2, 1'b0, 0);
    xact(1'b1, BASE + 32'd4096, 32'h77, 2'd0, 1'b0, 0);

    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 11);
      case (k)
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + 32'd4096 + 32'($urandom_range(0, 3));
        2:       a = $urandom | 32'h8000_0000;
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      xact(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom_range(0, 2));
    end
`ifdef DMEM_MMIO_EN
    check("mmio_final", mmio, mmio_m);
`endif

    // Zero-wait-state instance: request and response held high back to back.
    @(negedge clk);
    z_we = 1'b1; z_addr = BASE + 32'd16; z_wdata = 32'hCAFEF00D; z_size = 2'd2;
    z_valid = 1'b1; z_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("ws0_valid", {31'h0, z_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("ws0_ready", {31'h0, z_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i == 0) check("ws0_store_rdata", z_rdata, 32'd0);
      else if (i % 2 == 0) check("ws0_load_rdata", z_rdata, 32'hCAFEF00D);
      check("ws0_err", {31'h0, z_err}, 32'd0);
      z_we = 1'b0;
    end
    z_valid = 1'b0;
    z_rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
